// File: rtl/warp_scheduler.sv
// warp_scheduler: round-robin multi-warp core_state sequencer; define DIVERGENCE_CHECK_EN for the sticky divergence flag
module warp_scheduler #(
  parameter int WARPS = 4,
  parameter int THREADS_PER_WARP = 4,
  parameter int PC_BITS = 8,
  parameter int WARP_ID_BITS = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [7:0]                          thread_count,
  input  logic [2:0]                          fetcher_state,
  input  logic                                decoded_mem_read_enable,
  input  logic                                decoded_mem_write_enable,
  input  logic                                decoded_ret,
  input  logic [2*THREADS_PER_WARP-1:0]       lsu_state,
  input  logic [PC_BITS*THREADS_PER_WARP-1:0] next_pc,
  output logic [2:0]                          core_state,
  output logic [WARP_ID_BITS-1:0]             current_warp,
  output logic [PC_BITS-1:0]                  current_pc,
  output logic [THREADS_PER_WARP-1:0]         thread_enable,
  output logic                                diverged,
  output logic                                done
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, DONE} state_t;
  state_t state_q, state_d;
  logic [WARP_ID_BITS-1:0] warp_q, warp_d;
  logic [PC_BITS-1:0] pc_q [WARPS];
  logic [PC_BITS-1:0] pc_d [WARPS];
  logic [THREADS_PER_WARP-1:0] mask_q [WARPS];
  logic [THREADS_PER_WARP-1:0] mask_d [WARPS];
  logic [WARPS-1:0] wdone_q, wdone_d;
  logic div_q, div_d;
  logic [THREADS_PER_WARP-1:0] cur_mask;
  logic [PC_BITS-1:0] lead_pc;
  logic busy;
  always_comb begin
    cur_mask = mask_q[warp_q];
    lead_pc = '0;
    busy = 1'b0;
    for (int t = THREADS_PER_WARP - 1; t >= 0; t--)
      if (cur_mask[t]) lead_pc = next_pc[t*PC_BITS +: PC_BITS];
    for (int t = 0; t < THREADS_PER_WARP; t++)
      busy |= cur_mask[t] & (lsu_state[2*t] ^ lsu_state[2*t+1]);
    state_d = state_q;
    warp_d = warp_q;
    pc_d = pc_q;
    mask_d = mask_q;
    wdone_d = wdone_q;
    div_d = div_q;
    case (state_q)
      IDLE: if (start) begin
        for (int w = 0; w < WARPS; w++) begin
          for (int t = 0; t < THREADS_PER_WARP; t++)
            mask_d[w][t] = (w * THREADS_PER_WARP + t) < int'(thread_count);
          wdone_d[w] = ~|mask_d[w];
          pc_d[w] = '0;
        end
        div_d = 1'b0;
        warp_d = '0;
        state_d = thread_count == 8'd0 ? DONE : FETCH;
      end
      FETCH: state_d = fetcher_state == 3'b010 ? DECODE : FETCH;
      DECODE: state_d = REQUEST;
      REQUEST: state_d = WAIT;
      WAIT: state_d = busy && (decoded_mem_read_enable || decoded_mem_write_enable) ? WAIT : EXECUTE;
      EXECUTE: state_d = UPDATE;
      UPDATE: begin
        if (decoded_ret) wdone_d[warp_q] = 1'b1;
        else begin
          pc_d[warp_q] = lead_pc;
`ifdef DIVERGENCE_CHECK_EN
          for (int t = 0; t < THREADS_PER_WARP; t++)
            div_d |= cur_mask[t] && next_pc[t*PC_BITS +: PC_BITS] != lead_pc;
`endif
        end
        state_d = DONE;
        for (int k = WARPS; k >= 1; k--)
          if (!wdone_d[(int'(warp_q) + k) % WARPS]) begin
            warp_d = WARP_ID_BITS'((int'(warp_q) + k) % WARPS);
            state_d = FETCH;
          end
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      warp_q <= '0;
      pc_q <= '{default: '0};
      mask_q <= '{default: '0};
      wdone_q <= '0;
      div_q <= 1'b0;
    end else begin
      state_q <= state_d;
      warp_q <= warp_d;
      pc_q <= pc_d;
      mask_q <= mask_d;
      wdone_q <= wdone_d;
      div_q <= div_d;
    end
  end
  assign core_state = state_q;
  assign current_warp = warp_q;
  assign current_pc = pc_q[warp_q];
  assign thread_enable = state_q != IDLE && state_q != DONE ? cur_mask : '0;
  assign diverged = div_q;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_warp_scheduler.sv
// tb_warp_scheduler: vector table plus scoreboarded instruction sequences for warp_scheduler
module tb_warp_scheduler;
  logic clk = 0, reset = 0, start = 0;
  logic [7:0] thread_count = 0;
  logic [2:0] fetcher_state = 0;
  logic mem_rd = 0, mem_wr = 0, ret = 0;
  logic [7:0] lsu = 0;
  logic [31:0] npc = 0;
  logic [2:0] core_state;
  logic [1:0] current_warp;
  logic [7:0] current_pc;
  logic [3:0] thread_enable;
  logic diverged, done;
  int n_chk = 0, n_fail = 0;
  logic [3:0] m_mask [4];
  logic [7:0] m_pc [4];
  logic [3:0] m_done;
  int m_warp;
  logic m_div;
  typedef struct { logic [2:0] st; logic [1:0] warp; logic [7:0] pc; logic [3:0] te; logic dv; } exp_t;
  typedef struct { logic [7:0] tc; logic [2:0] st0; logic [3:0] te0; logic [1:0] w1; logic [3:0] te1; } vec_t;
  exp_t sb [$];
  vec_t vecs [7];
  always #5 clk = ~clk;
  warp_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .fetcher_state(fetcher_state), .decoded_mem_read_enable(mem_rd),
    .decoded_mem_write_enable(mem_wr), .decoded_ret(ret), .lsu_state(lsu),
    .next_pc(npc), .core_state(core_state), .current_warp(current_warp),
    .current_pc(current_pc), .thread_enable(thread_enable), .diverged(diverged), .done(done)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    reset = 0;
    start = 0;
    mem_rd = 0;
    ret = 0;
    lsu = 0;
    tick();
    reset = 1;
  endtask
  task automatic launch(input logic [7:0] tc);
    int n, k;
    n = tc > 16 ? 16 : int'(tc);
    for (int w = 0; w < 4; w++) begin
      k = n - 4 * w;
      k = k < 0 ? 0 : (k > 4 ? 4 : k);
      m_mask[w] = 4'((1 << k) - 1);
      m_pc[w] = 0;
      m_done[w] = k == 0;
    end
    m_warp = 0;
    m_div = 0;
    thread_count = tc;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic run_instr(input logic r, input logic [31:0] pcs, input logic mr, input logic [7:0] ls, input int hold);
    exp_t e;
    int cnt, lead, idx;
    logic dv;
    lsu = ls;
    mem_rd = mr;
    ret = r;
    npc = pcs;
    fetcher_state = 0;
    tick();
    check("fetch_hold", core_state, 1);
    fetcher_state = 3'b010;
    tick();
    fetcher_state = 0;
    check("decode", core_state, 2);
    tick();
    check("request", core_state, 3);
    tick();
    cnt = 0;
    while (core_state == 4 && cnt < 50) begin
      cnt++;
      if (cnt == hold) lsu = 0;
      tick();
    end
    check("wait_cycles", cnt, hold < 1 ? 1 : hold);
    check("execute", core_state, 5);
    tick();
    check("update", core_state, 6);
    check("update_te", thread_enable, m_mask[m_warp]);
    dv = 0;
    if (r) m_done[m_warp] = 1;
    else begin
      lead = -1;
      for (int t = 0; t < 4; t++) if (m_mask[m_warp][t] && lead < 0) lead = t;
      m_pc[m_warp] = pcs[lead*8 +: 8];
      for (int t = 0; t < 4; t++) if (m_mask[m_warp][t] && pcs[t*8 +: 8] != m_pc[m_warp]) dv = 1;
    end
`ifdef DIVERGENCE_CHECK_EN
    m_div |= dv;
`endif
    e.st = 7;
    for (int k = 1; k <= 4; k++) begin
      idx = (m_warp + k) % 4;
      if (!m_done[idx] && e.st == 7) begin
        e.st = 1;
        m_warp = idx;
      end
    end
    e.warp = 2'(m_warp);
    e.pc = m_pc[m_warp];
    e.te = e.st == 1 ? m_mask[m_warp] : 4'd0;
    e.dv = m_div;
    sb.push_back(e);
    tick();
    mem_rd = 0;
    ret = 0;
    lsu = 0;
    e = sb.pop_front();
    check("next_state", core_state, e.st);
    check("next_warp", current_warp, e.warp);
    check("next_pc", current_pc, e.pc);
    check("next_te", thread_enable, e.te);
    check("next_done", done, e.st == 7);
    check("diverged", diverged, e.dv);
  endtask
  initial begin
    vecs[0] = '{8'd0, 3'd7, 4'b0000, 2'd0, 4'b0000};
    vecs[1] = '{8'd1, 3'd1, 4'b0001, 2'd0, 4'b0001};
    vecs[2] = '{8'd4, 3'd1, 4'b1111, 2'd0, 4'b1111};
    vecs[3] = '{8'd5, 3'd1, 4'b1111, 2'd1, 4'b0001};
    vecs[4] = '{8'd6, 3'd1, 4'b1111, 2'd1, 4'b0011};
    vecs[5] = '{8'd16, 3'd1, 4'b1111, 2'd1, 4'b1111};
    vecs[6] = '{8'd200, 3'd1, 4'b1111, 2'd1, 4'b1111};
    tick();
    do_reset();
    check("rst_state", core_state, 0);
    check("rst_warp", current_warp, 0);
    check("rst_pc", current_pc, 0);
    check("rst_te", thread_enable, 0);
    check("rst_done", done, 0);
    check("rst_div", diverged, 0);
    for (int i = 0; i < 7; i++) begin
      do_reset();
      launch(vecs[i].tc);
      check("tbl_state", core_state, vecs[i].st0);
      check("tbl_te0", thread_enable, vecs[i].te0);
      check("tbl_done", done, vecs[i].st0 == 7);
      if (core_state == 1) begin
        run_instr(0, {4{8'd3}}, 0, 0, 0);
        check("tbl_w1", current_warp, vecs[i].w1);
        check("tbl_te1", thread_enable, vecs[i].te1);
      end
    end
    do_reset();
    launch(8'd6);
    run_instr(0, {8'd5, 8'd5, 8'd9, 8'd5}, 0, 0, 0);
    check("pc_lead", m_pc[0], 5);
`ifdef DIVERGENCE_CHECK_EN
    check("div_set", diverged, 1);
`else
    check("div_off", diverged, 0);
`endif
    run_instr(0, {8'd1, 8'd2, 8'd7, 8'd7}, 1, 8'b01_00_00_10, 5);
    check("w1_pc", m_pc[1], 7);
    run_instr(1, {4{8'd20}}, 0, 0, 0);
    check("after_ret0", current_warp, 1);
    run_instr(0, {4{8'd8}}, 0, 0, 0);
    check("only_w1", current_warp, 1);
    run_instr(1, {4{8'd9}}, 0, 0, 0);
    start = 1;
    thread_count = 8'd6;
    tick();
    tick();
    start = 0;
    check("done_hold", core_state, 7);
    check("done_flag", done, 1);
    do_reset();
    launch(8'd6);
    lsu = 8'h02;
    mem_rd = 1;
    fetcher_state = 3'b010;
    tick();
    fetcher_state = 0;
    tick();
    tick();
    tick();
    check("in_wait", core_state, 4);
    reset = 0;
    tick();
    check("mid_rst_state", core_state, 0);
    check("mid_rst_te", thread_enable, 0);
    check("mid_rst_pc", current_pc, 0);
    check("mid_rst_done", done, 0);
    reset = 1;
    mem_rd = 0;
    lsu = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
